// File: rtl/uart_pkg.sv
// Shared defaults and constants for the UART baud-tick generator.
package uart_pkg;

    localparam int UART_OVS_DEF    = 16;
    localparam int UART_CNT_W_DEF  = 16;
    localparam int UART_FRAC_W_DEF = 4;
    localparam int UART_DIV_MIN    = 2;

endpackage

// File: rtl/uart_frac_div.sv
// Fractional clock divider: shadow divisor, cycle counter, optional fraction accumulator
// (present only when UART_BAUD_FRAC_EN is defined), cfg_err and the oversample tick.
module uart_frac_div
    import uart_pkg::*;
#(
    parameter int CNT_W  = UART_CNT_W_DEF,
    parameter int FRAC_W = UART_FRAC_W_DEF
) (
    input  logic              uart_clk,
    input  logic              rstN,
    input  logic              cfg_en_i,
    input  logic [CNT_W-1:0]  div_int_i,
    input  logic [FRAC_W-1:0] div_frac_i,
    input  logic              resync_i,
    input  logic              reload_i,
    output logic              hold_o,
    output logic              tc_o,
    output logic              os_tick_o,
    output logic              cfg_err_o
);

    logic [CNT_W-1:0] div_int_q, div_int_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic [CNT_W:0]   period_m1_s;
    logic             carry_s;
    logic             load_s;
    logic             active_s;
    logic             tc_s;
    logic             os_tick_q;
    logic             cfg_err_q;

    assign load_s      = !cfg_en_i || reload_i;
    assign active_s    = cfg_en_i && !resync_i && (div_int_q >= CNT_W'(UART_DIV_MIN));
    // One bit wider than the divisor so the maximum divisor plus a carry cannot wrap.
    assign period_m1_s = {1'b0, div_int_q} + (CNT_W+1)'(carry_s) - (CNT_W+1)'(1);
    assign tc_s        = active_s && ({1'b0, cnt_q} == period_m1_s);

    // Shadow divisor reload and cycle counter next-state.
    always_comb begin
        div_int_d = div_int_q;
        cnt_d     = cnt_q;
        if (load_s) begin
            div_int_d = div_int_i;
        end else begin
            div_int_d = div_int_q;
        end
        if (!active_s || tc_s) begin
            cnt_d = {CNT_W{1'b0}};
        end else begin
            cnt_d = cnt_q + CNT_W'(1);
        end
    end

`ifdef UART_BAUD_FRAC_EN
    logic [FRAC_W-1:0] frac_q, frac_d;
    logic [FRAC_W-1:0] acc_q, acc_d;
    logic              carry_q, carry_d;
    logic [FRAC_W:0]   acc_sum_s;

    assign acc_sum_s = {1'b0, acc_q} + {1'b0, frac_q};
    assign carry_s   = carry_q;

    // Fraction shadow and accumulator; the carry stretches the following period by one cycle.
    always_comb begin
        frac_d  = frac_q;
        acc_d   = acc_q;
        carry_d = carry_q;
        if (load_s) begin
            frac_d = div_frac_i;
        end else begin
            frac_d = frac_q;
        end
        if (!active_s) begin
            acc_d   = {FRAC_W{1'b0}};
            carry_d = 1'b0;
        end else if (tc_s) begin
            acc_d   = acc_sum_s[FRAC_W-1:0];
            carry_d = acc_sum_s[FRAC_W];
        end else begin
            acc_d   = acc_q;
            carry_d = carry_q;
        end
    end

    // Fraction state registers.
    always_ff @(posedge uart_clk or negedge rstN) begin
        if (!rstN) begin
            frac_q  <= {FRAC_W{1'b0}};
            acc_q   <= {FRAC_W{1'b0}};
            carry_q <= 1'b0;
        end else begin
            frac_q  <= frac_d;
            acc_q   <= acc_d;
            carry_q <= carry_d;
        end
    end
`else
    logic frac_unused_s;

    assign frac_unused_s = ^div_frac_i;
    assign carry_s       = 1'b0;
`endif

    // Divisor, counter and registered outputs.
    always_ff @(posedge uart_clk or negedge rstN) begin
        if (!rstN) begin
            div_int_q <= {CNT_W{1'b0}};
            cnt_q     <= {CNT_W{1'b0}};
            os_tick_q <= 1'b0;
            cfg_err_q <= 1'b0;
        end else begin
            div_int_q <= div_int_d;
            cnt_q     <= cnt_d;
            os_tick_q <= tc_s;
            cfg_err_q <= (div_int_d < CNT_W'(UART_DIV_MIN));
        end
    end

    assign hold_o    = !active_s;
    assign tc_o      = tc_s;
    assign os_tick_o = os_tick_q;
    assign cfg_err_o = cfg_err_q;

endmodule

// File: rtl/uart_baud_gen.sv
// UART baud-tick generator: oversample, mid-bit and bit-end enables in the uart_clk domain.
// Define UART_BAUD_FRAC_EN to enable the fractional divisor.
module uart_baud_gen
    import uart_pkg::*;
#(
    parameter int CNT_W  = UART_CNT_W_DEF,
    parameter int OVS    = UART_OVS_DEF,
    parameter int FRAC_W = UART_FRAC_W_DEF
) (
    input  logic              uart_clk,
    input  logic              rstN,
    input  logic              cfg_en,
    input  logic [CNT_W-1:0]  cfg_div_int,
    input  logic [FRAC_W-1:0] cfg_div_frac,
    input  logic              rx_resync,
    output logic              os_tick,
    output logic              mid_tick,
    output logic              bit_tick,
    output logic              cfg_err
);

    localparam int              PH_W   = $clog2(OVS);
    localparam logic [PH_W-1:0] MID_PH = PH_W'(OVS/2 - 1);
    localparam logic [PH_W-1:0] END_PH = PH_W'(OVS - 1);

    logic            hold_s;
    logic            tc_s;
    logic            os_tick_s;
    logic            cfg_err_s;
    logic [PH_W-1:0] ph_q, ph_d;
    logic            mid_tick_q, mid_tick_d;
    logic            bit_tick_q, bit_tick_d;

    uart_frac_div #(
        .CNT_W  (CNT_W),
        .FRAC_W (FRAC_W)
    ) u_frac_div (
        .uart_clk   (uart_clk),
        .rstN       (rstN),
        .cfg_en_i   (cfg_en),
        .div_int_i  (cfg_div_int),
        .div_frac_i (cfg_div_frac),
        .resync_i   (rx_resync),
        .reload_i   (bit_tick_q),
        .hold_o     (hold_s),
        .tc_o       (tc_s),
        .os_tick_o  (os_tick_s),
        .cfg_err_o  (cfg_err_s)
    );

    // Phase counter; mid/bit decode looks at the phase before it advances.
    always_comb begin
        ph_d       = ph_q;
        mid_tick_d = 1'b0;
        bit_tick_d = 1'b0;
        if (hold_s) begin
            ph_d = {PH_W{1'b0}};
        end else if (tc_s) begin
            ph_d       = ph_q + PH_W'(1);
            mid_tick_d = (ph_q == MID_PH);
            bit_tick_d = (ph_q == END_PH);
        end else begin
            ph_d = ph_q;
        end
    end

    // Phase and tick registers.
    always_ff @(posedge uart_clk or negedge rstN) begin
        if (!rstN) begin
            ph_q       <= {PH_W{1'b0}};
            mid_tick_q <= 1'b0;
            bit_tick_q <= 1'b0;
        end else begin
            ph_q       <= ph_d;
            mid_tick_q <= mid_tick_d;
            bit_tick_q <= bit_tick_d;
        end
    end

    assign os_tick  = os_tick_s;
    assign mid_tick = mid_tick_q;
    assign bit_tick = bit_tick_q;
    assign cfg_err  = cfg_err_s;

endmodule

// File: tb/tb_uart_baud_gen.sv
// Self-checking bench for uart_baud_gen: per-cycle reference model plus directed literal checks.
module tb_uart_baud_gen;

    localparam int CNT_W  = 16;
    localparam int OVS    = 16;
    localparam int FRAC_W = 4;
`ifdef UART_BAUD_FRAC_EN
    localparam bit FRAC_ON = 1'b1;
`else
    localparam bit FRAC_ON = 1'b0;
`endif

    logic              uart_clk = 1'b0;
    logic              rstN     = 1'b0;
    logic              cfg_en   = 1'b0;
    logic              rx_resync = 1'b0;
    logic [CNT_W-1:0]  cfg_div_int = 16'd5;
    logic [FRAC_W-1:0] cfg_div_frac = 4'd0;
    logic              os_tick, mid_tick, bit_tick, cfg_err;

    int n_cmp = 0;
    int n_bad = 0;

    // Reference model state: absolute edge index, edge at which the current interval began,
    // ticks since alignment, fraction accumulator and shadow divisor.
    int   cyc = 0;
    int   start = 1;
    int   ntick = 0;
    int   acc = 0;
    int   carry = 0;
    int   sh_int = 0;
    int   sh_frac = 0;
    bit   m_active, m_tc;
    logic m_os = 1'b0, m_mid = 1'b0, m_bit = 1'b0, m_err = 1'b0;
    logic [3:0] exp_v, got_v;

    int hit_os[$];
    int hit_mid[$];
    int hit_bit[$];

    always #5 uart_clk = ~uart_clk;

    uart_baud_gen #(.CNT_W(CNT_W), .OVS(OVS), .FRAC_W(FRAC_W)) dut (
        .uart_clk     (uart_clk),
        .rstN         (rstN),
        .cfg_en       (cfg_en),
        .cfg_div_int  (cfg_div_int),
        .cfg_div_frac (cfg_div_frac),
        .rx_resync    (rx_resync),
        .os_tick      (os_tick),
        .mid_tick     (mid_tick),
        .bit_tick     (bit_tick),
        .cfg_err      (cfg_err)
    );

    task automatic check(input string name, input int act, input int exp);
        n_cmp++;
        if (act != exp) begin
            n_bad++;
            $display("FAIL %s: got %0d expected %0d", name, act, exp);
        end
    endtask

    function automatic int at(input int q[$], input int i);
        if (i >= 0 && i < q.size()) return q[i];
        return -1;
    endfunction

    // Compare DUT against model every cycle, then advance the model across the next edge.
    initial begin
        forever begin
            @(negedge uart_clk);
            exp_v = rstN ? {m_os, m_mid, m_bit, m_err} : 4'b0000;
            got_v = {os_tick, mid_tick, bit_tick, cfg_err};
            n_cmp++;
            if (got_v !== exp_v) begin
                n_bad++;
                if (n_bad <= 20)
                    $display("FAIL cycle_cmp @%0d: os/mid/bit/err got %b expected %b", cyc, got_v, exp_v);
            end
            if (!rstN) begin
                sh_int = 0; sh_frac = 0; acc = 0; carry = 0; ntick = 0;
                start = cyc + 1;
                m_os = 1'b0; m_mid = 1'b0; m_bit = 1'b0; m_err = 1'b0;
            end else begin
                m_active = cfg_en && (sh_int >= 2) && !rx_resync;
                m_tc = m_active && ((cyc - start) == (sh_int + carry - 1));
                m_os  = m_tc;
                m_mid = m_tc && ((ntick % OVS) == (OVS/2 - 1));
                m_bit_next_calc();
                if (!m_active) begin
                    start = cyc + 1; ntick = 0; acc = 0; carry = 0;
                end else if (m_tc) begin
                    start = cyc + 1;
                    ntick++;
                    if (FRAC_ON) begin
                        acc   = acc + sh_frac;
                        carry = (acc >= (1 << FRAC_W)) ? 1 : 0;
                        acc   = acc % (1 << FRAC_W);
                    end
                end
                m_err = (sh_int < 2);
            end
            cyc++;
        end
    end

    // Shadow reload uses the bit tick of the current cycle, so update it after the reload decision.
    logic m_bit_new;
    task automatic m_bit_next_calc();
        m_bit_new = m_tc && ((ntick % OVS) == (OVS - 1));
        if (!cfg_en || m_bit) begin
            sh_int  = int'(cfg_div_int);
            sh_frac = int'(cfg_div_frac);
        end
        m_bit = m_bit_new;
    endtask

    task automatic step();
        @(posedge uart_clk);
        #1;
    endtask

    // Count edges from the sampling edge of the last input change; record output hits.
    task automatic scan(input int budget);
        hit_os.delete(); hit_mid.delete(); hit_bit.delete();
        for (int n = 1; n <= budget; n++) begin
            @(posedge uart_clk);
            #1 rx_resync = 1'b0;
            @(negedge uart_clk);
            if (os_tick)  hit_os.push_back(n);
            if (mid_tick) hit_mid.push_back(n);
            if (bit_tick) hit_bit.push_back(n);
        end
    endtask

    task automatic wait_model(input int ph, input int cn, input int budget, output bit ok);
        ok = 1'b0;
        for (int i = 0; i < budget; i++) begin
            step();
            if ((ntick % OVS) == ph && (cn < 0 || (cyc - start) == cn)) begin
                ok = 1'b1;
                break;
            end
        end
    endtask

    initial begin
        bit ok;
        int n11;
        repeat (5) step();
        rstN = 1'b1;

        // Idle after reset
        scan(50);
        check("idle_ticks", hit_os.size() + hit_mid.size() + hit_bit.size(), 0);
        check("idle_err", int'(cfg_err), 0);

        // Integer divide by 5
        step(); cfg_en = 1'b1;
        scan(170);
        check("int_os0", at(hit_os, 0), 5);
        check("int_os1", at(hit_os, 1), 10);
        check("int_mid0", at(hit_mid, 0), 40);
        check("int_mid1", at(hit_mid, 1), 120);
        check("int_bit0", at(hit_bit, 0), 80);
        check("int_bit1", at(hit_bit, 1), 160);

        // Fractional 10 + 4/16
        step(); cfg_en = 1'b0; cfg_div_int = 16'd10; cfg_div_frac = 4'd4;
        step(); cfg_en = 1'b1;
        scan(400);
        check("frac_os0", at(hit_os, 0), 10);
        check("frac_sum16", at(hit_os, 16) - at(hit_os, 0), FRAC_ON ? 164 : 160);
        n11 = 0;
        for (int i = 0; i < 16; i++)
            if (at(hit_os, i + 1) - at(hit_os, i) == 11) n11++;
        check("frac_n11", n11, FRAC_ON ? 4 : 0);
        check("frac_bit", at(hit_bit, 1) - at(hit_bit, 0), FRAC_ON ? 164 : 160);

        // Resync at ph=9, cnt=3
        step(); cfg_en = 1'b0; cfg_div_int = 16'd5; cfg_div_frac = 4'd0;
        step(); cfg_en = 1'b1;
        wait_model(9, 3, 400, ok);
        check("resync_wait", int'(ok), 1);
        rx_resync = 1'b1;
        scan(100);
        check("resync_os0", at(hit_os, 0), 6);
        check("resync_mid0", at(hit_mid, 0), 41);

        // Invalid divisor, then recovery
        step(); cfg_en = 1'b0; cfg_div_int = 16'd1;
        step(); cfg_en = 1'b1;
        scan(100);
        check("bad_ticks", hit_os.size() + hit_mid.size() + hit_bit.size(), 0);
        check("bad_err", int'(cfg_err), 1);
        step(); cfg_en = 1'b0; cfg_div_int = 16'd4;
        step(); cfg_en = 1'b1;
        scan(20);
        check("rec_err", int'(cfg_err), 0);
        check("rec_os0", at(hit_os, 0), 4);
        check("rec_os1", at(hit_os, 1), 8);

        // Mid-bit reconfiguration 5 -> 7 at ph=3
        step(); cfg_en = 1'b0; cfg_div_int = 16'd5;
        step(); cfg_en = 1'b1;
        wait_model(3, -1, 400, ok);
        check("recfg_wait", int'(ok), 1);
        cfg_div_int = 16'd7;
        scan(120);
        check("recfg_old", at(hit_os, 12) - at(hit_os, 11), 5);
        check("recfg_bitpos", at(hit_bit, 0), at(hit_os, 12));
        check("recfg_new0", at(hit_os, 13) - at(hit_os, 12), 7);
        check("recfg_new1", at(hit_os, 14) - at(hit_os, 13), 7);

        // Randomized traffic checked by the per-cycle model
        for (int blk = 0; blk < 25; blk++) begin
            step(); cfg_en = 1'b0;
            cfg_div_int  = ($urandom_range(0, 9) == 0) ? CNT_W'($urandom_range(0, 1))
                                                       : CNT_W'($urandom_range(2, 9));
            cfg_div_frac = FRAC_W'($urandom_range(0, 15));
            step(); cfg_en = 1'b1;
            for (int c = 0; c < 300; c++) begin
                step();
                rx_resync = ($urandom_range(0, 99) == 0);
                if ($urandom_range(0, 199) == 0) cfg_div_int = CNT_W'($urandom_range(0, 9));
                if ($urandom_range(0, 299) == 0) cfg_en = 1'b0;
                else if (!cfg_en && $urandom_range(0, 9) == 0) cfg_en = 1'b1;
                if (blk == 7 && c == 150) rstN = 1'b0;
                if (blk == 7 && c == 153) rstN = 1'b1;
            end
        end
        rx_resync = 1'b0;
        step(); step();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
